// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared types, note codes and default song tables for the melody sequencer
package melody_pkg;

    localparam int NOTE_W_DEF = 4;
    localparam int LEN_W_DEF  = 2;

    localparam logic [NOTE_W_DEF-1:0] NOTE_REST = '0;
    localparam logic [NOTE_W_DEF-1:0] NOTE_END  = '1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } state_e;

    typedef struct packed {
        logic [NOTE_W_DEF-1:0] note;
        logic [LEN_W_DEF-1:0]  length;
    } rom_entry_t;

    // Song 0 is a short tune; every entry past its table reads as END.
    localparam int SONG0_LEN = 4;
    localparam rom_entry_t SONG0_TUNE [SONG0_LEN] = '{
        '{4'd5, 2'd2},
        '{4'd0, 2'd0},
        '{4'd6, 2'd1},
        '{NOTE_END, 2'd0}
    };

    // Other songs are END-free fills of the whole depth, so they always wrap.
    function automatic int pattern_note(input int song, input int step, input int note_w);
        return 1 + ((5 * step + song) % ((1 << note_w) - 2));
    endfunction

    function automatic int pattern_len(input int song, input int step, input int len_w);
        return (step + song) % (1 << len_w);
    endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - song ROM, addr = {song, step}, one-cycle registered read
module melody_rom
    import melody_pkg::*;
#(
    parameter int NOTE_W     = 4,
    parameter int LEN_W      = 2,
    parameter int NUM_SONGS  = 2,
    parameter int SONG_DEPTH = 64,
    parameter int ADDR_W     = 7
) (
    input  logic                    clk,
    input  logic [ADDR_W-1:0]       addr_i,
    output logic [NOTE_W+LEN_W-1:0] data_o
);

    localparam int ENTRY_W = NOTE_W + LEN_W;
    localparam int TOTAL   = NUM_SONGS * SONG_DEPTH;
    localparam int IDX_W   = $clog2(TOTAL * ENTRY_W);

    function automatic logic [TOTAL*ENTRY_W-1:0] build_rom();
        logic [TOTAL*ENTRY_W-1:0] bits;
        logic [NOTE_W-1:0]        n;
        logic [LEN_W-1:0]         l;
        bits = '0;
        for (int s = 0; s < NUM_SONGS; s++) begin
            for (int i = 0; i < SONG_DEPTH; i++) begin
                if (s == 0) begin
                    if (i < SONG0_LEN) begin
                        n = (SONG0_TUNE[i].note == NOTE_END) ? '1 : NOTE_W'(SONG0_TUNE[i].note);
                        l = LEN_W'(SONG0_TUNE[i].length);
                    end else begin
                        n = '1;
                        l = '0;
                    end
                end else begin
                    n = NOTE_W'(pattern_note(s, i, NOTE_W));
                    l = LEN_W'(pattern_len(s, i, LEN_W));
                end
                bits[(s * SONG_DEPTH + i) * ENTRY_W +: ENTRY_W] = {n, l};
            end
        end
        return bits;
    endfunction

    localparam logic [TOTAL*ENTRY_W-1:0] ROM_BITS = build_rom();

    logic [IDX_W-1:0]   base;
    logic [ENTRY_W-1:0] data_q;

    assign base = IDX_W'(int'(addr_i) * ENTRY_W);

    always_ff @(posedge clk) begin
        data_q <= ROM_BITS[base +: ENTRY_W];
    end

    assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps through a ROM melody, emitting note/length per step
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int NOTE_W         = 4,
    parameter int LEN_W          = 2,
    parameter int NUM_SONGS      = 2,
    parameter int SONG_DEPTH     = 64,
    parameter int TICKS_PER_UNIT = 1000,
    localparam int SEL_W         = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int STEP_W        = $clog2(SONG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SEL_W-1:0]  song_sel,
    input  logic              loop_en,
    input  logic              manual,
    input  logic              next,
    input  logic              pause,
    output logic [NOTE_W-1:0] note,
    output logic [LEN_W-1:0]  length,
    output logic              run,
    output logic              note_valid,
    output logic              done,
    output logic [STEP_W-1:0] step
);

    localparam int TIMER_W = $clog2((2 ** LEN_W) * TICKS_PER_UNIT);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     song_q, song_d, song_clamped;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_limit;
    logic [NOTE_W-1:0]    note_q, note_d, entry_note;
    logic [LEN_W-1:0]     length_q, length_d, entry_len;
    logic                 run_q, run_d;
    logic                 note_valid_q, note_valid_d;
    logic                 done_q, done_d;
    logic                 wrap_q, wrap_d;
    logic [NOTE_W+LEN_W-1:0] rom_data;

    // Addressed by next-state so the entry for the current step is ready during FETCH.
    melody_rom #(
        .NOTE_W    (NOTE_W),
        .LEN_W     (LEN_W),
        .NUM_SONGS (NUM_SONGS),
        .SONG_DEPTH(SONG_DEPTH),
        .ADDR_W    (SEL_W + STEP_W)
    ) u_rom (
        .clk   (clk),
        .addr_i({song_d, step_d}),
        .data_o(rom_data)
    );

    assign entry_note  = rom_data[NOTE_W+LEN_W-1 -: NOTE_W];
    assign entry_len   = rom_data[LEN_W-1:0];
    assign timer_limit = TIMER_W'((int'(length_q) + 1) * TICKS_PER_UNIT - 1);

    always_comb begin
        song_clamped = song_sel;
        if (int'(song_sel) >= NUM_SONGS) begin
            song_clamped = SEL_W'(NUM_SONGS - 1);
        end
    end

    always_comb begin
        state_d      = state_q;
        song_d       = song_q;
        step_d       = step_q;
        timer_d      = timer_q;
        note_d       = note_q;
        length_d     = length_q;
        run_d        = run_q;
        wrap_d       = wrap_q;
        note_valid_d = 1'b0;
        done_d       = 1'b0;

        if (load) begin
            song_d  = song_clamped;
            step_d  = '0;
            wrap_d  = 1'b0;
            timer_d = '0;
            run_d   = 1'b1;
            state_d = FETCH;
        end else if (!pause) begin
            unique case (state_q)
                IDLE: ;
                FETCH: begin
                    if (entry_note == '1 || wrap_q) begin
                        done_d = 1'b1;
                        wrap_d = 1'b0;
                        step_d = '0;
                        if (!loop_en) begin
                            state_d  = IDLE;
                            run_d    = 1'b0;
                            note_d   = NOTE_W'(NOTE_REST);
                            length_d = '0;
                        end
                    end else begin
                        note_d       = entry_note;
                        length_d     = entry_len;
                        note_valid_d = 1'b1;
                        timer_d      = '0;
                        state_d      = PLAY;
                    end
                end
                PLAY: begin
                    if (manual ? next : (timer_q == timer_limit)) begin
                        step_d  = step_q + 1'b1;
                        wrap_d  = (step_q == '1);
                        state_d = FETCH;
                    end else if (!manual) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Holding the timer at zero in manual mode makes a switch to auto start a fresh count.
        if (state_q == PLAY && manual) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            song_q       <= '0;
            step_q       <= '0;
            timer_q      <= '0;
            note_q       <= '0;
            length_q     <= '0;
            run_q        <= 1'b0;
            note_valid_q <= 1'b0;
            done_q       <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            step_q       <= step_d;
            timer_q      <= timer_d;
            note_q       <= note_d;
            length_q     <= length_d;
            run_q        <= run_d;
            note_valid_q <= note_valid_d;
            done_q       <= done_d;
            wrap_q       <= wrap_d;
        end
    end

    assign note       = note_q;
    assign length     = length_q;
    assign run        = run_q;
    assign note_valid = note_valid_q;
    assign done       = done_q;
    assign step       = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized scoreboard bench for melody_sequencer
module tb_melody_sequencer;

    localparam int TPU   = 4;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst, load, loop_en, manual, next, pause;
    logic [0:0] song_sel;
    logic [3:0] note;
    logic [1:0] length;
    logic       run, note_valid, done;
    logic [5:0] step;

    always #5 clk = ~clk;

    melody_sequencer #(
        .NOTE_W(4), .LEN_W(2), .NUM_SONGS(2), .SONG_DEPTH(DEPTH), .TICKS_PER_UNIT(TPU)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .song_sel(song_sel), .loop_en(loop_en),
        .manual(manual), .next(next), .pause(pause), .note(note), .length(length),
        .run(run), .note_valid(note_valid), .done(done), .step(step)
    );

    int   cyc = 0;
    logic pause_prev = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        pause_prev <= pause;
    end

    typedef struct {
        int cyc;
        bit dn;
        int note;
        int len;
        int step;
        bit run;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    function automatic int ref_note(input int s, input int i);
        if (s == 0) return (i == 0) ? 5 : (i == 1) ? 0 : (i == 2) ? 6 : 15;
        return 1 + (5 * i + s) % 14;
    endfunction

    function automatic int ref_len(input int s, input int i);
        if (s == 0) return (i == 0) ? 2 : (i == 2) ? 1 : 0;
        return (i + s) % 4;
    endfunction

    task automatic push_ev(input int c, input bit dn, input int n, input int l, input int s, input bit r);
        ev_t e;
        e.cyc = c; e.dn = dn; e.note = n; e.len = l; e.step = s; e.run = r;
        exp_q.push_back(e);
    endtask

    // Expected strobes for an auto-tempo song whose first FETCH is cycle t0, up to t_limit.
    task automatic push_auto(input int song, input int t0, input bit loop, input int t_limit,
                             input int ps, input int pl);
        int t, i, d, ln, ll;
        bit wrapped;
        t = t0; i = 0; ln = 0; ll = 0; wrapped = 1'b0;
        while (t < t_limit) begin
            if (wrapped || ref_note(song, i) == 15) begin
                if (loop) push_ev(t + 1, 1'b1, ln, ll, 0, 1'b1);
                else      push_ev(t + 1, 1'b1, 0, 0, 0, 1'b0);
                if (!loop) return;
                i = 0; wrapped = 1'b0; t = t + 1;
            end else begin
                ln = ref_note(song, i);
                ll = ref_len(song, i);
                push_ev(t + 1, 1'b0, ln, ll, i, 1'b1);
                d = (ll + 1) * TPU;
                if (ps >= t + 1 && ps <= t + d) d = d + pl;
                t = t + 1 + d;
                if (i == DEPTH - 1) begin
                    i = 0; wrapped = 1'b1;
                end else begin
                    i = i + 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (note_valid || done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected cyc=%0d nv=%0b done=%0b note=%0d step=%0d",
                         cyc, note_valid, done, note, step);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.dn != done || mon_e.dn == note_valid ||
                    int'(note) != mon_e.note || int'(length) != mon_e.len ||
                    int'(step) != mon_e.step || run != mon_e.run || pause_prev) begin
                    errors++;
                    $display("FAIL strobe got cyc=%0d nv=%0b done=%0b note=%0d len=%0d step=%0d run=%0b paused=%0b want cyc=%0d done=%0b note=%0d len=%0d step=%0d run=%0b",
                             cyc, note_valid, done, note, length, step, run, pause_prev,
                             mon_e.cyc, mon_e.dn, mon_e.note, mon_e.len, mon_e.step, mon_e.run);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drain(input string name, input int budget, input bit rnd_next);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            next = rnd_next ? 1'($urandom_range(0, 1)) : 1'b0;
            tick(1);
            n++;
        end
        next = 1'b0;
        chk({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic truncate(input int c);
        while (exp_q.size() != 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
    endtask

    task automatic start(input int song);
        song_sel = 1'(song);
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_note"}, int'(note), 0);
        chk({name, "_length"}, int'(length), 0);
        chk({name, "_run"}, int'(run), 0);
        chk({name, "_step"}, int'(step), 0);
    endtask

    int L, L2, P, M, R, ps, pl;

    initial begin
        rst = 1'b1; load = 1'b0; loop_en = 1'b0; manual = 1'b0;
        next = 1'b0; pause = 1'b0; song_sel = 1'b0;
        tick(3);
        chk_zero("reset");
        chk("reset_nv", int'(note_valid), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        tick(2);

        for (int k = 0; k < 4; k++) begin
            L = cyc;
            ps = -1; pl = 0;
            if (k == 1) begin
                pl = 10; ps = L + 2 + $urandom_range(0, 11);
            end else if (k > 1) begin
                pl = $urandom_range(1, 15); ps = L + 2 + $urandom_range(0, 11);
            end
            push_auto(0, L + 1, 1'b0, L + 2000, ps, pl);
            start(0);
            if (ps >= 0) begin
                wait_until(ps);
                pause = 1'b1;
                tick(pl);
                pause = 1'b0;
            end
            drain("auto", 400, 1'b1);
            tick(2);
            chk("auto_end", int'({run, note}), 0);
        end

        for (int k = 0; k < 2; k++) begin
            manual = 1'b1;
            L = cyc;
            push_ev(L + 2, 1'b0, 5, 2, 0, 1'b1);
            start(0);
            P = L + 2 + $urandom_range(14, 30);
            wait_until(P);
            push_ev(P + 2, 1'b0, 0, 0, 1, 1'b1);
            next = 1'b1; tick(1); next = 1'b0;
            P = P + 2 + $urandom_range(14, 30);
            wait_until(P);
            push_ev(P + 2, 1'b0, 6, 1, 2, 1'b1);
            next = 1'b1; tick(2); next = 1'b0;
            if (k == 0) begin
                P = P + 2 + $urandom_range(14, 30);
                wait_until(P);
                push_ev(P + 2, 1'b1, 0, 0, 0, 1'b0);
                next = 1'b1; tick(1); next = 1'b0;
            end else begin
                M = P + $urandom_range(3, 20);
                wait_until(M);
                manual = 1'b0;
                push_ev(M + 9, 1'b1, 0, 0, 0, 1'b0);
            end
            drain("manual", 100, 1'b0);
            manual = 1'b0;
            tick(2);
        end

        loop_en = 1'b1;
        L = cyc;
        R = L + 60 + $urandom_range(0, 30);
        push_auto(0, L + 1, 1'b1, R, -1, 0);
        start(0);
        wait_until(R);
        rst = 1'b1;
        truncate(R);
        tick(1);
        chk_zero("loop_rst");
        drain("loop", 0, 1'b0);
        rst = 1'b0; loop_en = 1'b0;
        tick(1);

        L = cyc;
        push_auto(0, L + 1, 1'b0, L + 2000, -1, 0);
        start(0);
        L2 = L + $urandom_range(3, 25);
        wait_until(L2);
        truncate(L2);
        loop_en = 1'b1;
        R = L2 + 1000 + $urandom_range(0, 200);
        push_auto(1, L2 + 1, 1'b1, R, -1, 0);
        start(1);
        wait_until(R);
        rst = 1'b1;
        truncate(R);
        tick(1);
        chk_zero("wrap_rst");
        drain("wrap", 0, 1'b0);
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
